// File: rtl/ppt_pulse_sequencer_if.sv
// Control, configuration and status bundle of the PPT pulse sequencer.
// The master drives enable, trigger and shot configuration; the slave reports status.
interface ppt_pulse_sequencer_if #(
  parameter int CW = 8
);
  logic          en;
  logic          tick_in;
  logic [CW-1:0] charge_cycles;
  logic [3:0]    dead_cycles;
  logic [3:0]    fire_cycles;
  logic [CW-1:0] burst_len;
  logic          charge_out;
  logic          fire_out;
  logic          busy;
  logic [CW-1:0] pulse_cnt;
  logic          burst_done;
  logic          overrun;

  modport master (
    output en, tick_in, charge_cycles, dead_cycles, fire_cycles, burst_len,
    input  charge_out, fire_out, busy, pulse_cnt, burst_done, overrun
  );

  modport slave (
    input  en, tick_in, charge_cycles, dead_cycles, fire_cycles, burst_len,
    output charge_out, fire_out, busy, pulse_cnt, burst_done, overrun
  );
endinterface

// File: rtl/ppt_pulse_sequencer.sv
// Turns rising edges of the divided clock into charge / dead / fire shots,
// counting completed shots and flagging triggers dropped while a shot is in progress.
module ppt_pulse_sequencer #(
  parameter int CW = 8
) (
  input logic             clk,
  input logic             rst_n,
  ppt_pulse_sequencer_if.slave bus
);
  // The phase counter must hold both the CW-bit charge length and the 4-bit dead/fire lengths.
  localparam int KW = (CW > 4) ? CW : 4;

  typedef enum logic [1:0] {IDLE, CHARGE, DEAD, FIRE} state_t;

  state_t        state_reg, state_next;
  logic [KW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic          burst_done_reg, burst_done_next;
  logic          overrun_reg, overrun_next;
  logic          tick_q;
  logic          tick_rise;
  logic [KW-1:0] fire_load;
  logic [CW-1:0] pulse_inc;

  assign tick_rise = bus.tick_in & ~tick_q;
  assign fire_load = (bus.fire_cycles == 4'd0) ? KW'(1) : KW'(bus.fire_cycles);
  assign pulse_inc = pulse_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      pulse_cnt_reg  <= '0;
      burst_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pulse_cnt_reg  <= pulse_cnt_next;
      burst_done_reg <= burst_done_next;
      overrun_reg    <= overrun_next;
      tick_q         <= bus.tick_in;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pulse_cnt_next  = pulse_cnt_reg;
    burst_done_next = burst_done_reg;
    overrun_next    = overrun_reg;

    unique case (state_reg)
      IDLE: begin
        if (!bus.en) begin
          pulse_cnt_next  = '0;
          burst_done_next = 1'b0;
          overrun_next    = 1'b0;
        end else if (tick_rise && !burst_done_reg && (bus.charge_cycles != '0)) begin
          state_next = CHARGE;
          cnt_next   = KW'(bus.charge_cycles);
        end
      end
      CHARGE: begin
        if (!bus.en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == KW'(1)) begin
          if (bus.dead_cycles == 4'd0) begin
            state_next = FIRE;
            cnt_next   = fire_load;
          end else begin
            state_next = DEAD;
            cnt_next   = KW'(bus.dead_cycles);
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DEAD: begin
        if (!bus.en) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == KW'(1)) begin
          state_next = FIRE;
          cnt_next   = fire_load;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      FIRE: begin
        // The fire pulse always runs to full width; en only gates the count.
        if (cnt_reg == KW'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (bus.en) begin
            pulse_cnt_next = pulse_inc;
            if ((bus.burst_len != '0) && (pulse_inc == bus.burst_len))
              burst_done_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (bus.en && tick_rise && (state_reg != IDLE))
      overrun_next = 1'b1;
  end

  assign bus.charge_out = (state_reg == CHARGE);
  assign bus.fire_out   = (state_reg == FIRE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.pulse_cnt  = pulse_cnt_reg;
  assign bus.burst_done = burst_done_reg;
  assign bus.overrun    = overrun_reg;
endmodule

// File: doc/ppt_pulse_sequencer.md
# ppt_pulse_sequencer

Converts the divided-clock output of the clock divider into a pulse sequence for the thruster power stage. Each rising edge of the divided clock triggers one shot: a charge phase, an optional dead time, then a fire pulse. The block counts shots, supports finite bursts or continuous firing, and flags triggers that arrive while a shot is still in progress. It runs entirely in the `clk` domain that drives the clock divider.

## Interface
Parameters:
- `CW`, 8: width of `charge_cycles`, the charge counter, `burst_len` and `pulse_cnt`.

Ports:
- `clk`  in  1  system clock; same clock as the divider.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  sequencer enable. Low aborts charge/dead and clears status.
- `tick_in`  in  1  divided clock level. Generated from `clk`, so no synchronizer.
- `charge_cycles`  in  CW  charge phase length in clk cycles. 0 means shots are suppressed.
- `dead_cycles`  in  4  gap between charge and fire. 0 means no gap.
- `fire_cycles`  in  4  fire pulse length. 0 is treated as 1.
- `burst_len`  in  CW  shots per burst. 0 means continuous.
- `charge_out`  out  1  high during CHARGE.
- `fire_out`  out  1  high during FIRE.
- `busy`  out  1  state != IDLE.
- `pulse_cnt`  out  CW  number of completed shots.
- `burst_done`  out  1  sticky; the burst is complete.
- `overrun`  out  1  sticky; a trigger was dropped because a shot was in progress.

## Operation
Edge detection:
- `tick_q` registers `tick_in` and resets to 0.
- `tick_rise = tick_in & ~tick_q`.

FSM states: IDLE, CHARGE, DEAD, FIRE. All outputs are registered or decoded from state, so there are no glitches.
- **IDLE → CHARGE** when all of these hold: `tick_rise`, `en`, `!burst_done`, and `charge_cycles != 0`. Load the down-counter with `charge_cycles`.
- **CHARGE:**
  - Decrement the counter each cycle.
  - When counter == 1: go to DEAD (load `dead_cycles`), or go directly to FIRE if `dead_cycles == 0`.
- **DEAD:** decrement; when counter == 1, go to FIRE and load `max(fire_cycles, 1)`.
- **FIRE:**
  - Decrement; when counter == 1, go to IDLE.
  - On that exit, if `en` = 1: `pulse_cnt += 1`.
  - If in addition `burst_len != 0` and the new `pulse_cnt == burst_len`: set `burst_done`.
- Configuration inputs are sampled only when a phase counter is loaded. Changing them mid-phase does not affect the current phase.
- `en` = 0:
  - In CHARGE or DEAD: go to IDLE on the next edge; `charge_out` drops.
  - In FIRE: the pulse runs to completion (no runt pulse), with no count increment.
  - In IDLE: clear `pulse_cnt`, `burst_done` and `overrun`.
- `overrun`: set when `tick_rise` occurs with `en` = 1 and state != IDLE. That trigger is dropped, not queued.
- `pulse_cnt` wraps modulo 2^CW in continuous mode.
- `tick_rise` in the same cycle as the FIRE exit: the trigger is dropped and `overrun` is set, because the state is still FIRE in that cycle.
- A trigger while `burst_done` = 1 is ignored silently (no overrun).

## Timing
- Reset values: all outputs 0, state IDLE, `tick_q` 0, counter 0.
- Latency: if `tick_in` is sampled high at edge E0 with `tick_q` = 0, then `charge_out` = 1 from E0 onward.
- Phase durations:
  - `charge_out` is high for exactly `charge_cycles` cycles.
  - DEAD lasts `dead_cycles` cycles, during which both outputs are low.
  - `fire_out` is high for `max(fire_cycles, 1)` cycles.
  - `charge_out` and `fire_out` are never high together.
- Shot length: L = `charge_cycles` + `dead_cycles` + `max(fire_cycles, 1)`. The trigger period must be ≥ L + 1 cycles to avoid overrun.
- `pulse_cnt` and `burst_done` update on the same edge that drops `fire_out`.
- Reset mid-shot: outputs go to 0 asynchronously and the state returns to IDLE immediately.

## Test plan
- Single shot: `charge_cycles`=5, `dead_cycles`=2, `fire_cycles`=3, one `tick_in` rise → `charge_out` high 5 cycles starting 1 cycle after the rise, then 2 low cycles, then `fire_out` high 3 cycles; `pulse_cnt`=1; `busy` high 10 cycles.
- Burst: `burst_len`=3, tick period 32 clk, `charge_cycles`=4 → exactly 3 shots; `burst_done`=1 after the third `fire_out` falls; the 4th tick produces no activity and `overrun`=0. Dropping `en` for 1 cycle clears `pulse_cnt` to 0 and `burst_done` to 0.
- Overrun: `charge_cycles`=20, tick period 8 → first shot completes normally; ticks inside the shot are dropped and `overrun`=1; the next tick after IDLE starts a new shot.
- Zero fields: `dead_cycles`=0, `fire_cycles`=0 → FIRE follows CHARGE with no gap and `fire_out` is high 1 cycle. `charge_cycles`=0 → no shot, `busy` stays 0.
- Abort: `en` dropped during CHARGE → `charge_out` low next cycle, `pulse_cnt` unchanged. `en` dropped during FIRE → `fire_out` completes its full width, no increment.
- Async reset: assert `rst_n`=0 mid-FIRE → `fire_out`, `busy`, `pulse_cnt` and `overrun` all 0 immediately; the first tick after release starts a clean shot.
